// File: rtl/maquina_cafe_param.sv
// maquina_cafe_param: parametrised coffee-machine order, payment and dispense controller.
// Define MAQUINA_TIMEOUT_EN to add a payment inactivity timeout with automatic refund.
module maquina_cafe_param #(
  parameter int PRICE_W          = 16,
  parameter int PRECIO_BASE      = 500,
  parameter int PASO_PRECIO      = 100,
  parameter int AZUCAR_MAX       = 9,
  parameter int CICLOS_DISPENSAR = 4,
  parameter int TIMEOUT_CICLOS   = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pedido_valido,
  input  logic [2:0]         entrada_cafe,
  input  logic [1:0]         entrada_tamano,
  input  logic [3:0]         entrada_azucar,
  input  logic               moneda_valida,
  input  logic [PRICE_W-1:0] moneda_valor,
  input  logic               cancelar,
  output logic [PRICE_W-1:0] salida_precio,
  output logic [PRICE_W-1:0] salida_cambio,
  output logic               cambio_valido,
  output logic [3:0]         salida_azucar,
  output logic               salida_concentracion,
  output logic               salida_leche,
  output logic               salida_espuma,
  output logic               ocupado,
  output logic               error_pedido
);

  typedef enum logic [1:0] {
    IDLE,
    PAGO,
    DISPENSAR,
    CAMBIO
  } estado_t;

  localparam int CNT_W =
    (CICLOS_DISPENSAR > 1) ? $clog2(CICLOS_DISPENSAR) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN =
    CNT_W'(CICLOS_DISPENSAR - 1);
  localparam logic [3:0] AZ_MAX = 4'(AZUCAR_MAX);

  estado_t            estado, estado_n;
  logic [2:0]         cafe_q, cafe_n;
  logic [3:0]         azucar_q, azucar_n;
  logic [PRICE_W-1:0] precio_q, precio_n;
  logic [PRICE_W-1:0] acum_q, acum_n;
  logic [PRICE_W-1:0] cambio_q, cambio_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               error_q, error_n;
  logic               ocupado_q;
  logic               timeout_evt;

  logic               pedido_ok;
  logic [3:0]         azucar_sat;
  logic [PRICE_W-1:0] precio_calc;
  logic [PRICE_W-1:0] moneda_ef;
  logic [PRICE_W:0]   suma;
  logic [PRICE_W-1:0] acum_sum;
  logic [2:0]         receta;
  logic               dispensando;

  assign pedido_ok  = (entrada_cafe <= 3'd4)
                   && (entrada_tamano != 2'd3);
  assign azucar_sat = (entrada_azucar > AZ_MAX)
                    ? AZ_MAX : entrada_azucar;
  assign precio_calc = PRICE_W'(
    (PRECIO_BASE + int'(entrada_cafe) * PASO_PRECIO)
    * (int'(entrada_tamano) + 1));

  // Saturating coin accumulation; the carry bit flags overflow.
  assign moneda_ef = moneda_valida ? moneda_valor : '0;
  assign suma      = {1'b0, acum_q} + {1'b0, moneda_ef};
  assign acum_sum  = suma[PRICE_W] ? '1 : suma[PRICE_W-1:0];

`ifdef MAQUINA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [TO_W-1:0] TO_FIN =
    TO_W'(TIMEOUT_CICLOS - 1);

  logic [TO_W-1:0] to_q;

  assign timeout_evt = (estado == PAGO)
                    && !moneda_valida
                    && (to_q == TO_FIN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q <= '0;
    end else if (estado != PAGO || moneda_valida) begin
      to_q <= '0;
    end else begin
      to_q <= to_q + TO_W'(1);
    end
  end
`else
  // No inactivity counter: payment waits indefinitely.
  assign timeout_evt = (TIMEOUT_CICLOS < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= IDLE;
      cafe_q    <= '0;
      azucar_q  <= '0;
      precio_q  <= '0;
      acum_q    <= '0;
      cambio_q  <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado    <= estado_n;
      cafe_q    <= cafe_n;
      azucar_q  <= azucar_n;
      precio_q  <= precio_n;
      acum_q    <= acum_n;
      cambio_q  <= cambio_n;
      cnt_q     <= cnt_n;
      error_q   <= error_n;
      ocupado_q <= (estado_n != IDLE);
    end
  end

  always_comb begin
    estado_n = estado;
    cafe_n   = cafe_q;
    azucar_n = azucar_q;
    precio_n = precio_q;
    acum_n   = acum_q;
    cambio_n = cambio_q;
    cnt_n    = '0;
    error_n  = 1'b0;
    unique case (estado)
      IDLE: begin
        if (pedido_valido) begin
          if (pedido_ok) begin
            cafe_n   = entrada_cafe;
            azucar_n = azucar_sat;
            precio_n = precio_calc;
            acum_n   = '0;
            estado_n = PAGO;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      PAGO: begin
        acum_n = acum_sum;
        // Cancel wins over completion and timeout.
        if (cancelar) begin
          cambio_n = acum_sum;
          estado_n = CAMBIO;
        end else if (acum_q >= precio_q) begin
          estado_n = DISPENSAR;
        end else if (timeout_evt) begin
          cambio_n = acum_sum;
          estado_n = CAMBIO;
        end
      end
      DISPENSAR: begin
        if (cnt_q == CNT_FIN) begin
          cambio_n = acum_q - precio_q;
          estado_n = CAMBIO;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      CAMBIO: begin
        precio_n = '0;
        estado_n = IDLE;
      end
      default: begin
        estado_n = IDLE;
      end
    endcase
  end

  // Recipe bits: concentration, milk, foam.
  always_comb begin
    receta = 3'b000;
    unique case (1'b1)
      cafe_q == 3'd0: receta = 3'b100;
      cafe_q == 3'd1: receta = 3'b000;
      cafe_q == 3'd2: receta = 3'b010;
      cafe_q == 3'd3: receta = 3'b111;
      cafe_q == 3'd4: receta = 3'b101;
      default:        receta = 3'b000;
    endcase
  end

  assign dispensando = (estado == DISPENSAR);

  assign salida_concentracion = dispensando & receta[2];
  assign salida_leche         = dispensando & receta[1];
  assign salida_espuma        = dispensando & receta[0];
  assign salida_azucar        = dispensando ? azucar_q : 4'd0;

  assign salida_precio = precio_q;
  assign salida_cambio = cambio_q;
  assign cambio_valido = (estado == CAMBIO);
  assign ocupado       = ocupado_q;
  assign error_pedido  = error_q;

endmodule

// File: tb/tb_maquina_cafe_param.sv
// Bench for maquina_cafe_param: vector table, corner sequences, random orders.
// Covers the timeout path when MAQUINA_TIMEOUT_EN is defined.
module tb_maquina_cafe_param;

  localparam int W  = 16;
  localparam int CD = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         pedido_valido = 1'b0;
  logic [2:0]   entrada_cafe = '0;
  logic [1:0]   entrada_tamano = '0;
  logic [3:0]   entrada_azucar = '0;
  logic         moneda_valida = 1'b0;
  logic [W-1:0] moneda_valor = '0;
  logic         cancelar = 1'b0;
  logic [W-1:0] salida_precio;
  logic [W-1:0] salida_cambio;
  logic         cambio_valido;
  logic [3:0]   salida_azucar;
  logic         salida_concentracion;
  logic         salida_leche;
  logic         salida_espuma;
  logic         ocupado;
  logic         error_pedido;

  maquina_cafe_param dut (
    .clock                (clock),
    .reset                (reset),
    .pedido_valido        (pedido_valido),
    .entrada_cafe         (entrada_cafe),
    .entrada_tamano       (entrada_tamano),
    .entrada_azucar       (entrada_azucar),
    .moneda_valida        (moneda_valida),
    .moneda_valor         (moneda_valor),
    .cancelar             (cancelar),
    .salida_precio        (salida_precio),
    .salida_cambio        (salida_cambio),
    .cambio_valido        (cambio_valido),
    .salida_azucar        (salida_azucar),
    .salida_concentracion (salida_concentracion),
    .salida_leche         (salida_leche),
    .salida_espuma        (salida_espuma),
    .ocupado              (ocupado),
    .error_pedido         (error_pedido)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] cafe;
    logic [1:0] tam;
    logic [3:0] az;
    bit         ok;
    int         precio;
    logic [2:0] rec;
    logic [3:0] az_out;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    pedido_valido = 1'b0;
    moneda_valida = 1'b0;
    cancelar      = 1'b0;
  endtask

  task automatic order(input logic [2:0] c,
                       input logic [1:0] t,
                       input logic [3:0] a);
    pedido_valido  = 1'b1;
    entrada_cafe   = c;
    entrada_tamano = t;
    entrada_azucar = a;
    step();
    pedido_valido = 1'b0;
  endtask

  task automatic pay(input int v);
    moneda_valida = 1'b1;
    moneda_valor  = W'(v);
    step();
    moneda_valida = 1'b0;
  endtask

  function automatic logic [2:0] receta(input int c);
    case (c)
      0: return 3'b100;
      1: return 3'b000;
      2: return 3'b010;
      3: return 3'b111;
      4: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [2:0] disp();
    return {salida_concentracion, salida_leche, salida_espuma};
  endfunction

  task automatic check_dispense(input logic [2:0] rec,
                                input logic [3:0] az,
                                input bit noise);
    for (int i = 0; i < CD; i++) begin
      chk("disp_recipe", disp(), rec);
      chk("disp_azucar", salida_azucar, az);
      chk("disp_busy", ocupado, 1);
      if (noise) begin
        moneda_valida = 1'b1;
        moneda_valor  = W'(1000);
        cancelar      = 1'b1;
        pedido_valido = 1'b1;
      end
      step();
    end
    quiet();
  endtask

  task automatic rand_txn();
    int c, t, a, price, paid, add, val, exp_out;
    bit ok, coin, canc, refund, done;
    c = $urandom_range(0, 7);
    t = $urandom_range(0, 3);
    a = $urandom_range(0, 15);
    ok = (c <= 4) && (t <= 2);
    order(3'(c), 2'(t), 4'(a));
    if (!ok) begin
      chk("rnd_err", error_pedido, 1);
      chk("rnd_err_idle", ocupado, 0);
      step();
      chk("rnd_err_off", error_pedido, 0);
      return;
    end
    price = ((500 + c * 100) * (t + 1)) % 65536;
    chk("rnd_price", salida_precio, price);
    paid = 0;
    done = 0;
    refund = 0;
    exp_out = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      coin = ($urandom_range(0, 3) != 0);
      val  = $urandom_range(1, 12) * 50;
      canc = (k == 39) || ($urandom_range(0, 24) == 0);
      add  = coin ? val : 0;
      moneda_valida = coin;
      moneda_valor  = W'(val);
      cancelar      = canc;
      if (canc) begin
        refund = 1;
        exp_out = sat(paid + add);
        done = 1;
      end else if (paid >= price) begin
        exp_out = sat(paid + add) - price;
        done = 1;
      end else begin
        paid = sat(paid + add);
      end
      step();
      if (!done) begin
        chk("rnd_pago_busy", ocupado, 1);
        chk("rnd_pago_cv", cambio_valido, 0);
      end
    end
    quiet();
    if (!refund)
      check_dispense(receta(c), 4'((a > 9) ? 9 : a), 0);
    else
      chk("rnd_refund_nodisp", disp(), 0);
    chk("rnd_cv", cambio_valido, 1);
    chk("rnd_cambio", salida_cambio, exp_out);
    step();
    chk("rnd_idle", ocupado, 0);
    chk("rnd_precio_clr", salida_precio, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;

    tbl[0] = '{3'd0, 2'd0, 4'd0,  1'b1, 500,  3'b100, 4'd0};
    tbl[1] = '{3'd1, 2'd1, 4'd5,  1'b1, 1200, 3'b000, 4'd5};
    tbl[2] = '{3'd2, 2'd1, 4'd3,  1'b1, 1400, 3'b010, 4'd3};
    tbl[3] = '{3'd3, 2'd2, 4'd12, 1'b1, 2400, 3'b111, 4'd9};
    tbl[4] = '{3'd4, 2'd0, 4'd15, 1'b1, 900,  3'b101, 4'd9};
    tbl[5] = '{3'd6, 2'd0, 4'd0,  1'b0, 0,    3'b000, 4'd0};
    tbl[6] = '{3'd2, 2'd3, 4'd0,  1'b0, 0,    3'b000, 4'd0};
    tbl[7] = '{3'd5, 2'd1, 4'd0,  1'b0, 0,    3'b000, 4'd0};
    tbl[8] = '{3'd4, 2'd2, 4'd9,  1'b1, 2700, 3'b101, 4'd9};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", ocupado, 0);
    chk("rst_precio", salida_precio, 0);
    chk("rst_cambio", salida_cambio, 0);
    chk("rst_cv", cambio_valido, 0);
    chk("rst_disp", disp(), 0);
    chk("rst_err", error_pedido, 0);
    @(negedge clock);
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      order(tbl[i].cafe, tbl[i].tam, tbl[i].az);
      if (!tbl[i].ok) begin
        chk("tbl_err", error_pedido, 1);
        chk("tbl_err_idle", ocupado, 0);
        chk("tbl_err_precio", salida_precio, 0);
        step();
        chk("tbl_err_pulse", error_pedido, 0);
      end else begin
        chk("tbl_precio", salida_precio, tbl[i].precio);
        chk("tbl_busy", ocupado, 1);
        pay(tbl[i].precio);
        chk("tbl_latency", disp(), 0);
        step();
        check_dispense(tbl[i].rec, tbl[i].az_out, 0);
        chk("tbl_cv", cambio_valido, 1);
        chk("tbl_cambio", salida_cambio, 0);
        step();
        chk("tbl_idle", ocupado, 0);
        chk("tbl_precio_clr", salida_precio, 0);
      end
    end

    // Latte medium, 1000 + 500, with ignored inputs during dispense.
    order(3'd2, 2'd1, 4'd3);
    chk("latte_precio", salida_precio, 1400);
    pay(1000);
    pay(500);
    chk("latte_wait", ocupado, 1);
    step();
    check_dispense(3'b010, 4'd3, 1);
    chk("latte_cv", cambio_valido, 1);
    chk("latte_cambio", salida_cambio, 100);
    step();
    chk("latte_idle", ocupado, 0);
    chk("latte_cv_off", cambio_valido, 0);
    chk("latte_hold", salida_cambio, 100);

    // Cappuccino large, coin then cancel.
    order(3'd3, 2'd2, 4'd1);
    chk("capu_precio", salida_precio, 2400);
    pay(200);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    chk("capu_nodisp", disp(), 0);
    chk("capu_cv", cambio_valido, 1);
    chk("capu_refund", salida_cambio, 200);
    step();
    chk("capu_idle", ocupado, 0);

    // Cancel beats completion; refund saturates.
    order(3'd0, 2'd0, 4'd0);
    pay(60000);
    moneda_valida = 1'b1;
    moneda_valor  = W'(60000);
    cancelar      = 1'b1;
    step();
    quiet();
    chk("sat_nodisp", disp(), 0);
    chk("sat_cv", cambio_valido, 1);
    chk("sat_refund", salida_cambio, 65535);
    step();

    // Reset during the second dispense cycle.
    order(3'd4, 2'd0, 4'd15);
    pay(900);
    step();
    chk("rstd_rec1", disp(), 3'b101);
    chk("rstd_az1", salida_azucar, 9);
    step();
    chk("rstd_rec2", disp(), 3'b101);
    #1;
    reset = 1'b1;
    #1;
    chk("rstd_disp", disp(), 0);
    chk("rstd_az", salida_azucar, 0);
    chk("rstd_busy", ocupado, 0);
    chk("rstd_precio", salida_precio, 0);
    chk("rstd_cambio", salida_cambio, 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    order(3'd0, 2'd0, 4'd2);
    chk("post_precio", salida_precio, 500);
    pay(500);
    step();
    check_dispense(3'b100, 4'd2, 0);
    chk("post_cv", cambio_valido, 1);
    chk("post_cambio", salida_cambio, 0);
    step();

    for (int n = 0; n < 30; n++) rand_txn();

    // Payment inactivity.
    order(3'd1, 2'd0, 4'd0);
    pay(300);
`ifdef MAQUINA_TIMEOUT_EN
    cyc = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      cyc++;
      seen = cambio_valido;
    end
    chk("to_seen", seen, 1);
    chk("to_cycles", cyc, 64);
    chk("to_refund", salida_cambio, 300);
    step();
    chk("to_idle", ocupado, 0);
`else
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (cambio_valido) seen = 1;
    end
    chk("nto_cv", seen, 0);
    chk("nto_busy", ocupado, 1);
    cancelar = 1'b1;
    step();
    cancelar = 1'b0;
    chk("nto_refund", salida_cambio, 300);
    step();
    chk("nto_idle", ocupado, 0);
    cyc = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
